// File: rtl/keyframe_loader.sv
// Hex-digit key entry plus frame counter, offered to the A5/1 core as {key, frame}
// over a valid/ready handshake; frame advances once per completed cipher frame.

module keyframe_nibble (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       we,
    input  logic [3:0] wd,
    output logic [3:0] q
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= 4'h0;
        else if (we)
            q <= wd;
    end
endmodule

module keyframe_loader #(
    parameter int                    KEY_NIBBLES = 16,
    parameter int                    FRAME_BITS  = 22,
    parameter logic [FRAME_BITS-1:0] FRAME_INIT  = 22'h000134,
    localparam int                   CW          = $clog2(KEY_NIBBLES + 1),
    localparam int                   KFW         = 4 * KEY_NIBBLES + FRAME_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      digit_in,
    input  logic            digit_valid,
    input  logic            backspace,
    input  logic            clear,
    input  logic            commit,
    input  logic            frame_ready,
    input  logic            frame_advance,
    output logic [KFW-1:0]  keyframe_out,
    output logic            frame_valid,
    output logic [CW-1:0]   key_count,
    output logic            key_full,
    output logic [1:0]      state_out
);
    typedef enum logic [1:0] {
        ENTRY  = 2'b00,
        LOADED = 2'b01,
        ACTIVE = 2'b10
    } state_t;

    state_t                          state, state_nxt;
    logic                            frame_valid_nxt;
    logic [KEY_NIBBLES-1:0][3:0]     key;
    logic [FRAME_BITS-1:0]           frame;
    logic                            in_entry;
    logic                            bs_go, dig_go, commit_go, accept_go, adv_go;

    assign key_full = (key_count == CW'(KEY_NIBBLES));
    assign in_entry = (state == ENTRY) && !clear;

    // An ignored strobe takes no action, so a lower-priority strobe may still act.
    assign bs_go     = in_entry && backspace && (key_count != '0);
    assign dig_go    = in_entry && !bs_go && digit_valid && !key_full;
    assign commit_go = in_entry && !bs_go && !dig_go && commit && key_full;
    assign accept_go = (state == LOADED) && !clear && frame_valid && frame_ready;
    assign adv_go    = (state == ACTIVE) && !clear && frame_advance;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ENTRY;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_valid <= frame_valid_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ENTRY;
        end else begin
            case (state)
                ENTRY:   if (commit_go) state_nxt = LOADED;
                LOADED:  if (accept_go) state_nxt = ACTIVE;
                ACTIVE:  if (adv_go)    state_nxt = LOADED;
                default: state_nxt = ENTRY;
            endcase
        end
    end

    // Output logic: frame_valid is registered from the next state
    always_comb begin
        frame_valid_nxt = (state_nxt == LOADED);
    end

    assign state_out = state;

    always_ff @(posedge clk) begin
        if (reset || clear)
            key_count <= '0;
        else if (bs_go)
            key_count <= key_count - CW'(1);
        else if (dig_go)
            key_count <= key_count + CW'(1);
    end

    // Counter naturally wraps all-ones to zero at FRAME_BITS width.
    always_ff @(posedge clk) begin
        if (reset || clear)
            frame <= FRAME_INIT;
        else if (adv_go)
            frame <= frame + FRAME_BITS'(1);
    end

    for (genvar i = 0; i < KEY_NIBBLES; i++) begin : g_nib
        logic       we;
        logic [3:0] wd;
        // Store at the write pointer, or zero the slot just below it on backspace.
        assign we = (dig_go && (key_count == CW'(i))) ||
                    (bs_go  && (key_count == CW'(i + 1)));
        assign wd = dig_go ? digit_in : 4'h0;
        keyframe_nibble u_nib (
            .clk   (clk),
            .reset (reset),
            .clr   (clear),
            .we    (we),
            .wd    (wd),
            .q     (key[i])
        );
    end

    assign keyframe_out = {key, frame};

endmodule

// File: tb/tb_keyframe_loader.sv
// Directed table-driven bench for keyframe_loader: default build plus a small
// wrap-around build (2 nibbles, 4-bit frame starting at all-ones).

module tb_keyframe_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  digit_in;
    logic        digit_valid, backspace, clear, commit, frame_ready, frame_advance;
    logic [85:0] keyframe_out;
    logic        frame_valid, key_full;
    logic [4:0]  key_count;
    logic [1:0]  state_out;

    keyframe_loader dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
        .backspace(backspace), .clear(clear), .commit(commit),
        .frame_ready(frame_ready), .frame_advance(frame_advance),
        .keyframe_out(keyframe_out), .frame_valid(frame_valid),
        .key_count(key_count), .key_full(key_full), .state_out(state_out)
    );

    logic [3:0]  s_digit_in;
    logic        s_digit_valid, s_commit, s_frame_ready, s_frame_advance;
    logic [11:0] s_keyframe_out;
    logic        s_frame_valid, s_key_full;
    logic [1:0]  s_key_count;
    logic [1:0]  s_state_out;

    keyframe_loader #(.KEY_NIBBLES(2), .FRAME_BITS(4), .FRAME_INIT(4'hF)) dut_s (
        .clk(clk), .reset(reset), .digit_in(s_digit_in), .digit_valid(s_digit_valid),
        .backspace(1'b0), .clear(1'b0), .commit(s_commit),
        .frame_ready(s_frame_ready), .frame_advance(s_frame_advance),
        .keyframe_out(s_keyframe_out), .frame_valid(s_frame_valid),
        .key_count(s_key_count), .key_full(s_key_full), .state_out(s_state_out)
    );

    typedef struct {
        logic        dv;
        logic [3:0]  d;
        logic        bs, clr, cm, rdy, adv;
        logic [4:0]  cnt;
        logic [1:0]  st;
        logic        fv;
        logic [63:0] key;
        logic [21:0] frm;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic dv, input logic [3:0] d, input logic bs, input logic clr,
                       input logic cm, input logic rdy, input logic adv, input logic [4:0] cnt,
                       input logic [1:0] st, input logic fv, input logic [63:0] key,
                       input logic [21:0] frm);
        vec_t v;
        v.dv = dv; v.d = d; v.bs = bs; v.clr = clr; v.cm = cm; v.rdy = rdy; v.adv = adv;
        v.cnt = cnt; v.st = st; v.fv = fv; v.key = key; v.frm = frm;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        digit_valid = 0; digit_in = 0; backspace = 0; clear = 0; commit = 0;
        frame_ready = 0; frame_advance = 0;
    endtask

    task automatic check_main(input string tag, input logic [4:0] cnt, input logic [1:0] st,
                              input logic fv, input logic [63:0] key, input logic [21:0] frm);
        chk({tag, ".keyframe"}, 128'(keyframe_out), 128'({key, frm}));
        chk({tag, ".count"},    128'(key_count), 128'(cnt));
        chk({tag, ".full"},     128'(key_full), 128'(cnt == 5'd16));
        chk({tag, ".state"},    128'(state_out), 128'(st));
        chk({tag, ".valid"},    128'(frame_valid), 128'(fv));
    endtask

    initial begin
        logic [63:0] k;
        logic [63:0] kfull;
        idle_inputs();
        s_digit_in = 0; s_digit_valid = 0; s_commit = 0; s_frame_ready = 0; s_frame_advance = 0;
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        check_main("reset", 5'd0, 2'b00, 1'b0, 64'h0, 22'h000134);
        chk("s_reset.keyframe", 128'(s_keyframe_out), 128'(12'h00F));
        chk("s_reset.state", 128'(s_state_out), 128'(2'b00));

        // Digits 1..F,0 accumulate with nibble 0 first.
        k = 64'h0;
        for (int i = 0; i < 16; i++) begin
            k[4*i +: 4] = 4'((i + 1) & 15);
            add(1, 4'((i + 1) & 15), 0, 0, 0, 0, 0, 5'(i + 1), 2'b00, 0, k, 22'h134);
        end
        kfull = 64'h0FEDCBA987654321;
        add(1, 4'h5, 0, 0, 0, 0, 0, 5'd16, 2'b00, 0, kfull, 22'h134);                 // 17th digit ignored
        add(0, 4'h0, 1, 0, 0, 0, 0, 5'd15, 2'b00, 0, kfull, 22'h134);                 // backspace when full
        add(1, 4'h7, 0, 0, 0, 0, 0, 5'd16, 2'b00, 0, 64'h7FEDCBA987654321, 22'h134);
        add(0, 4'h0, 1, 0, 0, 0, 0, 5'd15, 2'b00, 0, kfull, 22'h134);
        add(1, 4'h0, 0, 0, 0, 0, 0, 5'd16, 2'b00, 0, kfull, 22'h134);
        add(0, 4'h0, 0, 0, 1, 0, 0, 5'd16, 2'b01, 1, kfull, 22'h134);                 // commit
        for (int i = 0; i < 5; i++)
            add(0, 4'h0, 0, 0, 0, 0, 0, 5'd16, 2'b01, 1, kfull, 22'h134);             // ready low, hold
        add(1, 4'h3, 1, 0, 0, 0, 1, 5'd16, 2'b01, 1, kfull, 22'h134);                 // ignored in LOADED
        add(0, 4'h0, 0, 0, 0, 1, 0, 5'd16, 2'b10, 0, kfull, 22'h134);                 // accept
        add(1, 4'h3, 1, 0, 1, 0, 0, 5'd16, 2'b10, 0, kfull, 22'h134);                 // ignored in ACTIVE
        add(0, 4'h0, 0, 0, 0, 0, 1, 5'd16, 2'b01, 1, kfull, 22'h135);                 // advance
        add(0, 4'h0, 0, 0, 0, 1, 1, 5'd16, 2'b10, 0, kfull, 22'h135);                 // adv ignored in LOADED
        add(0, 4'h0, 0, 0, 0, 0, 1, 5'd16, 2'b01, 1, kfull, 22'h136);
        add(0, 4'h0, 0, 0, 0, 1, 0, 5'd16, 2'b10, 0, kfull, 22'h136);
        add(0, 4'h0, 0, 1, 0, 0, 0, 5'd0,  2'b00, 0, 64'h0, 22'h134);                 // clear in ACTIVE
        add(1, 4'hA, 0, 0, 0, 0, 0, 5'd1,  2'b00, 0, 64'hA, 22'h134);
        add(1, 4'hB, 0, 0, 0, 0, 0, 5'd2,  2'b00, 0, 64'hBA, 22'h134);
        add(1, 4'hC, 0, 0, 0, 0, 0, 5'd3,  2'b00, 0, 64'hCBA, 22'h134);
        add(0, 4'h0, 1, 0, 0, 0, 0, 5'd2,  2'b00, 0, 64'hBA, 22'h134);
        add(0, 4'h0, 1, 0, 0, 0, 0, 5'd1,  2'b00, 0, 64'hA, 22'h134);
        add(1, 4'hD, 0, 0, 0, 0, 0, 5'd2,  2'b00, 0, 64'hDA, 22'h134);
        add(0, 4'h0, 0, 0, 1, 0, 0, 5'd2,  2'b00, 0, 64'hDA, 22'h134);                // short commit ignored
        add(0, 4'h0, 1, 0, 0, 0, 0, 5'd1,  2'b00, 0, 64'hA, 22'h134);
        add(0, 4'h0, 1, 0, 0, 0, 0, 5'd0,  2'b00, 0, 64'h0, 22'h134);
        add(0, 4'h0, 1, 0, 0, 0, 0, 5'd0,  2'b00, 0, 64'h0, 22'h134);                 // no underflow
        add(1, 4'h6, 0, 0, 0, 0, 0, 5'd1,  2'b00, 0, 64'h6, 22'h134);
        add(1, 4'h9, 0, 1, 0, 0, 0, 5'd0,  2'b00, 0, 64'h0, 22'h134);                 // clear beats digit

        foreach (tbl[i]) begin
            digit_valid = tbl[i].dv; digit_in = tbl[i].d; backspace = tbl[i].bs;
            clear = tbl[i].clr; commit = tbl[i].cm; frame_ready = tbl[i].rdy;
            frame_advance = tbl[i].adv;
            @(posedge clk); #1;
            idle_inputs();
            check_main($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].st, tbl[i].fv, tbl[i].key, tbl[i].frm);
        end

        // Digit and commit together at count 15: digit stored, commit dropped.
        for (int i = 0; i < 15; i++) begin
            digit_valid = 1; digit_in = 4'h2;
            @(posedge clk); #1;
        end
        digit_valid = 1; digit_in = 4'h9; commit = 1;
        @(posedge clk); #1;
        idle_inputs();
        check_main("dig_commit", 5'd16, 2'b00, 1'b0, 64'h9222222222222222, 22'h134);
        // Second commit with frame_ready held high throughout.
        commit = 1; frame_ready = 1;
        @(posedge clk); #1;
        commit = 0;
        check_main("commit2", 5'd16, 2'b01, 1'b1, 64'h9222222222222222, 22'h134);
        @(posedge clk); #1;
        check_main("held_ready", 5'd16, 2'b10, 1'b0, 64'h9222222222222222, 22'h134);
        frame_advance = 1;
        @(posedge clk); #1;
        frame_advance = 0;
        check_main("adv_held", 5'd16, 2'b01, 1'b1, 64'h9222222222222222, 22'h135);
        @(posedge clk); #1;
        frame_ready = 0;
        check_main("b2b_accept", 5'd16, 2'b10, 1'b0, 64'h9222222222222222, 22'h135);

        // Small build: frame all-ones wraps to zero on one advance.
        s_digit_valid = 1; s_digit_in = 4'h3;
        @(posedge clk); #1;
        s_digit_in = 4'h4;
        @(posedge clk); #1;
        s_digit_valid = 0;
        chk("s_full", 128'(s_key_full), 128'(1'b1));
        s_commit = 1;
        @(posedge clk); #1;
        s_commit = 0;
        chk("s_loaded", 128'(s_state_out), 128'(2'b01));
        s_frame_ready = 1;
        @(posedge clk); #1;
        s_frame_ready = 0;
        chk("s_active", 128'(s_state_out), 128'(2'b10));
        s_frame_advance = 1;
        @(posedge clk); #1;
        s_frame_advance = 0;
        chk("s_wrap.keyframe", 128'(s_keyframe_out), 128'(12'h430));
        chk("s_wrap.valid", 128'(s_frame_valid), 128'(1'b1));
        chk("s_wrap.count", 128'(s_key_count), 128'(2'd2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keyframe_loader.md
# keyframe_loader

Parametrised successor to the fixed 64-bit key / 22-bit frame register. It collects hex digits from the PS/2 keyboard decoder into a key of configurable length, with an auto-incrementing write pointer and backspace. It holds a frame number that advances per A5/1 frame, and presents the concatenated {key, frame} word to the A5/1 cipher core over a valid/ready handshake. It sits between the PS/2 scancode-to-hex decoder and the A5/1 encrypt/decrypt core.

## Interface
Parameters:
- KEY_NIBBLES, default 16: key length in 4-bit digits (key width = 4*KEY_NIBBLES, min 1).
- FRAME_BITS, default 22: frame counter width.
- FRAME_INIT, default 22'h000134: frame value after reset/clear.

Ports:
- clk, in, 1: single clock; all state updates on rising edge.
- reset, in, 1: synchronous, active-high.
- digit_in, in, 4: hex digit from PS/2 decoder.
- digit_valid, in, 1: one-cycle strobe, digit_in is valid.
- backspace, in, 1: one-cycle strobe, delete last digit.
- clear, in, 1: one-cycle strobe, discard key, restart entry.
- commit, in, 1: one-cycle strobe, finish key entry.
- frame_ready, in, 1: cipher core accepts keyframe_out.
- frame_advance, in, 1: one-cycle strobe from core, frame finished.
- keyframe_out, out, 4*KEY_NIBBLES+FRAME_BITS: {key, frame}.
- frame_valid, out, 1: keyframe_out offered to core.
- key_count, out, clog2(KEY_NIBBLES+1): digits entered.
- key_full, out, 1: key_count == KEY_NIBBLES.
- state_out, out, 2: 00 ENTRY, 01 LOADED, 10 ACTIVE (debug/LCD).

## Operation
- Layout: frame in keyframe_out[FRAME_BITS-1:0]. Key nibble i in keyframe_out[FRAME_BITS+4i+3 : FRAME_BITS+4i]. The first digit entered is nibble 0.
- States:
  - ENTRY: collects digits.
  - LOADED: frame_valid=1, waiting for handshake.
  - ACTIVE: core running; waiting for frame_advance.
- Per-cycle priority (exactly one action per cycle): reset > clear > backspace > digit_valid > commit > frame_ready/frame_advance.
- reset or clear, any state:
  - key = 0, key_count = 0, frame = FRAME_INIT.
  - frame_valid = 0, state = ENTRY.
- ENTRY:
  - digit_valid with key_count < KEY_NIBBLES: nibble[key_count] = digit_in; key_count++.
  - digit_valid with key_count == KEY_NIBBLES: ignored.
  - backspace with key_count > 0: key_count--; nibble[key_count-1] = 0.
  - backspace with key_count == 0: ignored.
  - commit with key_full: go to LOADED, frame_valid = 1.
  - commit otherwise: ignored.
  - frame_ready, frame_advance: ignored.
- LOADED:
  - frame_valid && frame_ready: go to ACTIVE, frame_valid = 0.
  - digit_valid, backspace: ignored.
  - frame_advance: ignored.
- ACTIVE:
  - frame_advance: frame = frame + 1 mod 2^FRAME_BITS (all-ones wraps to 0); go to LOADED, frame_valid = 1.
  - digit_valid, backspace, commit: ignored.
  - Only clear returns to ENTRY.
- key_full is combinational from key_count. All other outputs are registered.

## Timing
- Every action is visible on outputs the cycle after the strobe edge.
- Reset values: keyframe_out = {0, FRAME_INIT}, frame_valid 0, key_count 0, key_full 0, state_out 00.
- Full entry takes KEY_NIBBLES strobes plus 1 commit. Earliest frame_valid is the cycle after commit.
- Handshake:
  - frame_valid stays high and keyframe_out is stable until the accepting frame_ready edge.
  - frame_ready may be held high; acceptance then occurs on the first cycle frame_valid is high.
- frame_advance to new frame_valid: 1 cycle. Back-to-back frames: 2 cycles minimum (handshake + advance).
- Backspace is possible in ENTRY even when key_full, including after entering the last digit and before commit.
- Clear during ACTIVE or LOADED aborts immediately; frame_valid is low the next cycle.
- digit_valid and commit in the same cycle at key_count = KEY_NIBBLES-1: digit is stored, commit is dropped. A second commit is required.

## Test plan
- Reset, then 16 digits 0x1..0xF,0x0, then commit: keyframe_out[85:22] = 64'h0FEDCBA987654321, [21:0] = 22'h000134, frame_valid = 1 the cycle after commit, state_out = 01.
- Enter 3 digits A,B,C, backspace twice, enter D: key_count = 2, nibble0 = A, nibble1 = D, nibble2 = 0. Commit with count < 16 leaves state_out at 00.
- 17th digit after key_full: ignored, key unchanged. Backspace at key_count = 0: ignored, no underflow.
- Loaded key, frame_ready held low 5 cycles: frame_valid and output stable. Assert frame_ready: ACTIVE. frame_advance: frame = 0x000135 and frame_valid = 1 next cycle.
- FRAME_BITS = 4, FRAME_INIT = 4'hF, KEY_NIBBLES = 2: one advance wraps frame to 0x0.
- Clear asserted in ACTIVE, and again simultaneously with digit_valid in ENTRY: both give key = 0, key_count = 0, frame = FRAME_INIT, state_out = 00. The digit is discarded.
